// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding,
// baud-select width and default build parameters.
package uart_pkg;

    localparam int BAUD_SEL_W           = 3;
    localparam int CLK_FREQ             = 100_000_000;
    localparam int N_REQ_DEFAULT        = 4;
    localparam int BUSY_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of requester, transmitter and status signals around the scheduler.
// master = scheduler side, slave = requesters/transmitter side.
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) ();

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]      req_valid;
    logic [8*N_REQ-1:0]    req_data;
    logic [N_REQ-1:0]      req_ready;
    logic [BAUD_SEL_W-1:0] cfg_baud_sel;
    logic [BAUD_SEL_W-1:0] baudrate_set;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic                  tx_done;
    logic [ID_W-1:0]       grant_id;
    logic                  err_timeout;
    logic [15:0]           frame_count;

    modport master (
        input  req_valid, req_data, cfg_baud_sel, tx_busy, tx_done,
        output req_ready, baudrate_set, tx_start, tx_data, grant_id,
               err_timeout, frame_count
    );

    modport slave (
        output req_valid, req_data, cfg_baud_sel, tx_busy, tx_done,
        input  req_ready, baudrate_set, tx_start, tx_data, grant_id,
               err_timeout, frame_count
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: the requester closest after last_grant
// (wrapping) wins; last_grant itself has the lowest priority.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             any,
    output logic [ID_W-1:0]  winner
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid request is written last.
    always_comb begin
        any    = 1'b0;
        winner = last;
        sum    = '0;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, last} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// Owns the transmitter baud select and only updates it between frames.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | track cfg baud, arbitrate pending requests
//   ST_START     | one-cycle tx_start / req_ready pulse, arm timeout
//   ST_WAIT_BUSY | wait for transmitter busy, abort on timeout
//   ST_WAIT_DONE | wait for end-of-frame pulse, count the frame
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEFAULT,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_scheduler_if.master bus
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    sched_state_t          state, state_next;
    logic                  any_req;
    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       last_grant;
    logic [7:0]            win_byte;
    logic [N_REQ-1:0]      win_onehot;
    logic                  timeout_hit;
    logic [TO_W-1:0]       to_cnt;

    logic [N_REQ-1:0]      req_ready_q;
    logic                  tx_start_q;
    logic [7:0]            tx_data_q;
    logic [BAUD_SEL_W-1:0] baud_q;
    logic [ID_W-1:0]       grant_q;
    logic                  err_q;
    logic [15:0]           frame_cnt;

    uart_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (bus.req_valid),
        .last   (last_grant),
        .any    (any_req),
        .winner (winner)
    );

    // Winner's byte and accept vector, selected with constant slices.
    always_comb begin
        win_byte   = '0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_byte      = bus.req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state logic; the timeout counter counts down to zero in WAIT_BUSY.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE:      if (any_req) state_next = ST_START;
            ST_START:     state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (to_cnt == '0) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (bus.tx_done) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Registered outputs, grant history, timeout and frame counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            baud_q      <= '0;
            grant_q     <= '0;
            last_grant  <= ID_W'(N_REQ - 1);
            err_q       <= 1'b0;
            frame_cnt   <= '0;
            to_cnt      <= '0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            if (state == ST_IDLE) begin
                baud_q <= bus.cfg_baud_sel;
                if (any_req) begin
                    tx_data_q   <= win_byte;
                    grant_q     <= winner;
                    last_grant  <= winner;
                    tx_start_q  <= 1'b1;
                    req_ready_q <= win_onehot;
                end
            end
            // N-1 preload: zero is reached on the last of BUSY_TIMEOUT idle cycles.
            if (state == ST_START) begin
                to_cnt <= TO_W'(BUSY_TIMEOUT - 1);
            end else if (state == ST_WAIT_BUSY && !bus.tx_busy && to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end
            if (timeout_hit) err_q <= 1'b1;
            if (state == ST_WAIT_DONE && bus.tx_done) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.baudrate_set = baud_q;
    assign bus.grant_id     = grant_q;
    assign bus.err_timeout  = err_q;
    assign bus.frame_count  = frame_cnt;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a grant scoreboard and a
// simple busy/done transmitter model.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(N)) bus ();

    uart_tx_scheduler #(.N_REQ(N), .BUSY_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   rdy_cnt[N];
    int   tx_mode  = 0;
    int   bcnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_start"},    32'(bus.tx_start),     32'd0);
        check({tag, "_req_ready"},   32'(bus.req_ready),    32'd0);
        check({tag, "_tx_data"},     32'(bus.tx_data),      32'd0);
        check({tag, "_baud"},        32'(bus.baudrate_set), 32'd0);
        check({tag, "_grant_id"},    32'(bus.grant_id),     32'd0);
        check({tag, "_err_timeout"}, 32'(bus.err_timeout),  32'd0);
        check({tag, "_frame_count"}, 32'(bus.frame_count),  32'd0);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_frames(input logic [15:0] target, input string tag);
        int n = 0;
        while (bus.frame_count !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_count"}, 32'(bus.frame_count), 32'(target));
    endtask

    task automatic request(input int id, input logic [7:0] data);
        bus.req_data[8*id +: 8] = data;
        sb_q.push_back('{id: id, data: data});
        bus.req_valid[id] = 1'b1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.cfg_baud_sel = '0;
        bus.tx_busy      = 1'b0;
        bus.tx_done      = 1'b0;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

        fork
            // Transmitter model: busy from the START cycle for 3 cycles, then a done pulse.
            forever begin
                @(negedge clk);
                bus.tx_done = 1'b0;
                if (bus.tx_start === 1'b1 && tx_mode == 0) begin
                    bus.tx_busy = 1'b1;
                    bcnt        = 3;
                end else if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) begin
                        bus.tx_busy = 1'b0;
                        bus.tx_done = 1'b1;
                    end
                end
            end
            // Grant monitor: pops the scoreboard on each start, retires the accepted request.
            forever begin
                @(negedge clk);
                if (bus.tx_start === 1'b1) begin
                    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        mon_e = sb_q.pop_front();
                        check("grant_tx_data",   32'(bus.tx_data),   32'(mon_e.data));
                        check("grant_id",        32'(bus.grant_id),  32'(mon_e.id));
                        check("grant_req_ready", 32'(bus.req_ready), 32'(1 << mon_e.id));
                    end
                end else if (bus.req_ready !== '0) begin
                    check("ready_without_start", 32'(bus.req_ready), 32'd0);
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ready[i] === 1'b1) begin
                        rdy_cnt[i]++;
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single request on requester 2: start one cycle after it is sampled.
        request(2, 8'hA5);
        @(negedge clk);
        check("t1_tx_start",  32'(bus.tx_start),  32'd1);
        check("t1_req_ready", 32'(bus.req_ready), 32'b0100);
        wait_frames(16'd1, "t1");

        // All four pending after reset: strict rotation 0,1,2,3.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        for (int i = 0; i < N; i++) request(i, 8'h10 + 8'(i));
        wait_frames(16'd4, "t2");
        check("t2_sb_drained", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < N; i++) check($sformatf("t2_ready_pulses_%0d", i), 32'(rdy_cnt[i]), 32'd1);

        // Baud select only follows cfg in IDLE.
        bus.cfg_baud_sel = 3'd1;
        repeat (2) @(negedge clk);
        check("t3_baud_idle", 32'(bus.baudrate_set), 32'd1);
        request(1, 8'h3C);
        wait_start("t3");
        bus.cfg_baud_sel = 3'd5;
        begin
            int n = 0;
            while (bus.frame_count === 16'd4 && n < 50) begin
                @(negedge clk);
                n++;
                if (bus.frame_count === 16'd4) check("t3_baud_hold", 32'(bus.baudrate_set), 32'd1);
            end
        end
        check("t3_frame_count", 32'(bus.frame_count), 32'd5);
        check("t3_baud_first_idle", 32'(bus.baudrate_set), 32'd1);
        @(negedge clk);
        check("t3_baud_updated", 32'(bus.baudrate_set), 32'd5);

        // Transmitter never goes busy: abort after 16 idle WAIT_BUSY cycles.
        tx_mode = 1;
        request(3, 8'hE7);
        wait_start("t4");
        repeat (16) @(negedge clk);
        check("t4_err_before", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        check("t4_err_after", 32'(bus.err_timeout), 32'd1);
        check("t4_frame_count", 32'(bus.frame_count), 32'd5);
        tx_mode = 0;
        request(0, 8'h5A);
        @(negedge clk);
        check("t4_next_start", 32'(bus.tx_start), 32'd1);
        wait_frames(16'd6, "t4_next");
        check("t4_err_sticky", 32'(bus.err_timeout), 32'd1);

        // Reset while in WAIT_DONE; the late done pulse must be ignored.
        request(1, 8'h77);
        @(negedge clk);
        check("t5_tx_start", 32'(bus.tx_start), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t5");
        reset = 1'b0;
        @(negedge clk);
        check("t5_late_done_frame_count", 32'(bus.frame_count), 32'd0);
        check("t5_no_start", 32'(bus.tx_start), 32'd0);

        // Frame counter wraps from 0xFFFF to 0.
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        check("t6_preload", 32'(bus.frame_count), 32'hFFFF);
        request(0, 8'hC3);
        wait_frames(16'h0000, "t6_wrap");

        repeat (3) @(negedge clk);
        check("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
